mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 156 +++++++++++++++
 tb/tb_mdu_iter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RV64 M-extension multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Latency: out_valid rises XLEN+1 cycles after the request cycle (XLEN CALC cycles, then DONE).
// Backpressure: result holds in DONE until out_ready; in_ready only in IDLE; flush/rst abort at once.
module mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      aluOp,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_f3;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  // hi/lo: product halves for multiply, remainder/quotient for divide
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  logic            is_m_op;
  logic            accept;
  logic            in_a_neg;
  logic            in_b_neg;
  logic [XLEN-1:0] in_a_mag;
  logic [XLEN-1:0] in_b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] nhi;
  logic [XLEN-1:0] nlo;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] res_n;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign is_m_op = (aluOp == 4'b1001) || (aluOp == 4'b1010) ||
                   (aluOp == 4'b1011) || (aluOp == 4'b1111);
  assign accept  = in_valid && in_ready && !flush && is_m_op;

  // Decode operand signedness from funct3 and form magnitudes of the incoming operands
  always_comb begin
    in_a_neg = 1'b0;
    in_b_neg = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin
        in_a_neg = src1[XLEN-1];
        in_b_neg = src2[XLEN-1];
      end
      3'b010:  in_a_neg = src1[XLEN-1];
      default: ;
    endcase
    in_a_mag = in_a_neg ? (~src1 + 1'b1) : src1;
    in_b_mag = in_b_neg ? (~src2 + 1'b1) : src2;
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (op_f3[2]) begin
      nhi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      nlo = {lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      nhi = mul_sum[XLEN:1];
      nlo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // Sign-correct and select the final result from the last step's values
  always_comb begin
    prod   = {nhi, nlo};
    prod_s = (a_neg ^ b_neg) ? (~prod + 1'b1) : prod;
    case (op_f3)
      3'b000:                 res_n = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_n = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        // divide by zero yields all-ones regardless of dividend sign
        if (b_mag == '0)           res_n = '1;
        else if (a_neg ^ b_neg)    res_n = ~nlo + 1'b1;
        else                       res_n = nlo;
      end
      // remainder follows the dividend's sign; x/0 leaves |x| here, so this restores src1
      default:                res_n = a_neg ? (~nhi + 1'b1) : nhi;
    endcase
  end

  // Control FSM with operand latching and datapath state
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      op_f3  <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_f3 <= funct3;
            a_neg <= in_a_neg;
            b_neg <= in_b_neg;
            a_mag <= in_a_mag;
            b_mag <= in_b_mag;
            hi    <= '0;
            // multiply shifts the multiplier out of lo; divide shifts the dividend out
            lo    <= funct3[2] ? in_a_mag : in_b_mag;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          hi  <= nhi;
          lo  <= nlo;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) begin
            result <= res_n;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic corner cases, latency, backpressure, flush and reset.
module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluOp;
  logic [2:0]  funct3;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int total;
  int bad;

  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_REM  = 4'b1011;
  localparam logic [3:0] OP_MULH = 4'b1111;

  mdu_iter #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .funct3(funct3), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts cycles from the request cycle (accept edge = 1) until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Presents one request, then scrambles the inputs so only latched operands can matter.
  task automatic do_op(input logic [3:0] op, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    aluOp = op; funct3 = f3; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; src1 = ~a; src2 = ~b; funct3 = ~f3;
    wait_done(lat);
    res = result;
  endtask

  // With out_ready high, out_valid must be a single-cycle pulse returning to IDLE.
  task automatic check_pulse(input string tag);
    @(posedge clk); #1;
    check({tag, "_pulse_ov"}, 64'(out_valid), 64'd0);
    check({tag, "_pulse_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] res;
    int lat;
    int seen;
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; aluOp = 4'b0; funct3 = 3'b0;
    src1 = '0; src2 = '0; flush = 1'b0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", result, 64'd0);
    rst = 1'b0;

    // mul 7 * -3 -> -21, latency 65
    do_op(OP_MUL, 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, res, lat);
    check("mul_lat", 64'(lat), 64'd65);
    check("mul_res", res, 64'hFFFF_FFFF_FFFF_FFEB);
    check_pulse("mul");

    // mulhu all-ones * all-ones -> high half 0xFFFF_FFFF_FFFF_FFFE
    do_op(OP_MULH, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    check("mulhu_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
    check_pulse("mulhu");

    // mulhsu -1 * 2 -> -2 over 128 bits, high half all-ones
    do_op(OP_MULH, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, res, lat);
    check("mulhsu_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    check_pulse("mulhsu");

    // mulh -5 * 3 = -15 -> high half all-ones
    do_op(OP_MULH, 3'b001, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, res, lat);
    check("mulh_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    check_pulse("mulh");

    // div/rem -7 / 2 -> -3 remainder -1
    do_op(OP_DIV, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, lat);
    check("div_res", res, 64'hFFFF_FFFF_FFFF_FFFD);
    check_pulse("div");
    do_op(OP_REM, 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, lat);
    check("rem_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    check_pulse("rem");

    // divu 100 / 7 = 14, remu = 2
    do_op(OP_DIV, 3'b101, 64'd100, 64'd7, res, lat);
    check("divu_res", res, 64'd14);
    check_pulse("divu");
    do_op(OP_REM, 3'b111, 64'd100, 64'd7, res, lat);
    check("remu_res", res, 64'd2);
    check_pulse("remu");

    // divide by zero: quotient all-ones, remainder src1, same latency
    do_op(OP_DIV, 3'b101, 64'd7, 64'd0, res, lat);
    check("divu0_lat", 64'(lat), 64'd65);
    check("divu0_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    check_pulse("divu0");
    do_op(OP_DIV, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, res, lat);
    check("div0_neg_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    check_pulse("div0_neg");
    do_op(OP_REM, 3'b110, 64'd7, 64'd0, res, lat);
    check("rem0_res", res, 64'd7);
    check_pulse("rem0");
    do_op(OP_REM, 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, res, lat);
    check("rem0_neg_res", res, 64'hFFFF_FFFF_FFFF_FFF9);
    check_pulse("rem0_neg");

    // signed overflow MIN / -1
    do_op(OP_DIV, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    check("ovf_div_res", res, 64'h8000_0000_0000_0000);
    check_pulse("ovf_div");
    do_op(OP_REM, 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    check("ovf_rem_res", res, 64'd0);
    check_pulse("ovf_rem");

    // backpressure: hold DONE for 10 cycles
    out_ready = 1'b0;
    do_op(OP_MUL, 3'b000, 64'd3, 64'd4, res, lat);
    check("bp_lat", 64'(lat), 64'd65);
    check("bp_res", res, 64'd12);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ov", 64'(out_valid), 64'd1);
      check("bp_hold_rdy", 64'(in_ready), 64'd0);
      check("bp_hold_res", result, 64'd12);
    end
    // release together with a new request: must not be accepted on the DONE->IDLE edge
    out_ready = 1'b1;
    aluOp = OP_MUL; funct3 = 3'b000; src1 = 64'd5; src2 = 64'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 64'(in_ready), 64'd1);
    check("bp_release_ov", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("reissue_accepted", 64'(in_ready), 64'd0);
    check("reissue_busy", 64'(busy), 64'd1);
    wait_done(lat);
    check("reissue_lat", 64'(lat), 64'd65);
    check("reissue_res", result, 64'd30);
    check_pulse("reissue");

    // flush at CALC cycle 30
    aluOp = OP_MULH; funct3 = 3'b011; src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", 64'(in_ready), 64'd1);
    check("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_ov", 64'(seen), 64'd0);

    // flush wins over a simultaneous request
    aluOp = OP_MUL; funct3 = 3'b000; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_req_rdy", 64'(in_ready), 64'd1);
    check("flush_vs_req_busy", 64'(busy), 64'd0);

    // non-M aluOp ignored
    aluOp = 4'b0000; funct3 = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    check("nonm_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("nonm_rdy2", 64'(in_ready), 64'd1);
    check("nonm_busy", 64'(busy), 64'd0);

    // reset mid-CALC abandons the operation
    aluOp = OP_DIV; funct3 = 3'b101; src1 = 64'd1000; src2 = 64'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_rdy", 64'(in_ready), 64'd1);
    check("midrst_ov", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_res", result, 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_ov", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
